uart_line_echo: RTL

Parametrised line-buffered echo engine between a byte-level UART receiver and a byte-level UART transmitter. It collects received bytes into an internal line buffer until a terminator or an idle timeout, then replays the line to the transmitter with an optional case conversion and an optional CR LF suffix. It also reports per-line status: length, overflow and dropped-byte count.

---
 rtl/uart_line_echo.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_line_echo.sv
// uart_line_echo: line-buffered echo engine between a byte-level UART receiver
// and a byte-level UART transmitter.
//
// Received bytes are collected into a line buffer until a terminator (CR or LF)
// or an idle timeout. The line is then replayed to the transmitter, optionally
// case-mapped, optionally followed by CR LF. Bytes arriving during replay are
// dropped and counted.
//
// Ports:
//   sys_clk, sys_rst_n  clock, asynchronous active-low reset
//   rx_data, rx_valid   received byte strobe (no backpressure)
//   tx_data, tx_valid,  transmit byte with valid/ready handshake
//   tx_ready
//   busy                high while a line is being replayed
//   line_done           one-cycle pulse when a line's echo completes
//   line_len, overflow  length / truncation of the last completed line
//   drop_cnt            saturating count of bytes received while busy
//   last_rx             most recent received byte
module uart_line_echo #(
  parameter int unsigned MAX_LEN      = 64,
  parameter int unsigned LEN_W        = $clog2(MAX_LEN + 1),
  parameter int unsigned IDLE_TIMEOUT = 0,
  parameter int unsigned CASE_MODE    = 0,
  parameter int unsigned APPEND_CRLF  = 1,
  parameter int unsigned SKIP_EMPTY   = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             line_done,
  output logic [LEN_W-1:0] line_len,
  output logic             overflow,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       last_rx
);

  localparam int unsigned PtrW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned IdleW    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam int unsigned IdleLast = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
  localparam logic [7:0] ChCr = 8'h0D;
  localparam logic [7:0] ChLf = 8'h0A;

  typedef enum logic [2:0] {StRecv, StLoad, StSend, StCr, StLf} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             pend_cr_q, pend_cr_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             line_done_q, line_done_d;
  logic [LEN_W-1:0] line_len_q, line_len_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;
  logic [7:0]       last_rx_q, last_rx_d;

  logic [7:0]       line_mem [MAX_LEN];
  logic             mem_we;
  logic             line_end;
  logic             finish;
  logic             is_term;

  function automatic logic [7:0] map_case(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (CASE_MODE == 1 && b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
    if (CASE_MODE == 2 && b >= 8'h41 && b <= 8'h5A) r = b + 8'h20;
    return r;
  endfunction

  assign is_term = (rx_data == ChCr) || (rx_data == ChLf);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    pend_cr_d   = pend_cr_q;
    idle_cnt_d  = idle_cnt_q;
    tx_data_d   = tx_data_q;
    line_done_d = 1'b0;
    line_len_d  = line_len_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    last_rx_d   = last_rx_q;
    mem_we      = 1'b0;
    line_end    = 1'b0;
    finish      = 1'b0;

    if (rx_valid) last_rx_d = rx_data;

    unique case (state_q)
      StRecv: begin
        if (rx_valid) begin
          idle_cnt_d = '0;
          if (pend_cr_q && rx_data == ChLf) begin
            // Second half of a CR LF pair: swallow it.
            pend_cr_d = 1'b0;
          end else begin
            pend_cr_d = (rx_data == ChCr);
            if (is_term) begin
              line_end = 1'b1;
            end else if (wr_ptr_q == MaxLen) begin
              ovf_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + LEN_W'(1);
            end
          end
        end else if (IDLE_TIMEOUT != 0 && wr_ptr_q != '0) begin
          if (idle_cnt_q == IdleW'(IdleLast)) line_end = 1'b1;
          else idle_cnt_d = idle_cnt_q + IdleW'(1);
        end

        if (line_end) begin
          idle_cnt_d = '0;
          if (wr_ptr_q == '0) begin
            if (SKIP_EMPTY == 0) begin
              if (APPEND_CRLF != 0) begin
                // Empty line goes straight to the suffix, no LOAD cycle.
                len_d     = '0;
                tx_data_d = ChCr;
                state_d   = StCr;
              end else begin
                line_done_d = 1'b1;
                line_len_d  = '0;
                overflow_d  = 1'b0;
              end
            end
          end else begin
            len_d    = wr_ptr_q;
            rd_ptr_d = '0;
            state_d  = StLoad;
          end
        end
      end

      StLoad: begin
        tx_data_d = map_case(line_mem[rd_ptr_q[PtrW-1:0]]);
        state_d   = StSend;
      end

      StSend: begin
        if (tx_ready) begin
          rd_ptr_d = rd_ptr_q + LEN_W'(1);
          if (rd_ptr_q + LEN_W'(1) < len_q) begin
            state_d = StLoad;
          end else if (APPEND_CRLF != 0) begin
            tx_data_d = ChCr;
            state_d   = StCr;
          end else begin
            finish = 1'b1;
          end
        end
      end

      StCr: begin
        if (tx_ready) begin
          tx_data_d = ChLf;
          state_d   = StLf;
        end
      end

      StLf: begin
        if (tx_ready) finish = 1'b1;
      end

      default: state_d = StRecv;
    endcase

    if (finish) begin
      state_d     = StRecv;
      line_done_d = 1'b1;
      line_len_d  = len_q;
      overflow_d  = ovf_q;
      wr_ptr_d    = '0;
      ovf_d       = 1'b0;
    end

    if (state_q != StRecv && rx_valid && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StRecv;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      pend_cr_q   <= 1'b0;
      idle_cnt_q  <= '0;
      tx_data_q   <= '0;
      line_done_q <= 1'b0;
      line_len_q  <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      last_rx_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      pend_cr_q   <= pend_cr_d;
      idle_cnt_q  <= idle_cnt_d;
      tx_data_q   <= tx_data_d;
      line_done_q <= line_done_d;
      line_len_q  <= line_len_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      last_rx_q   <= last_rx_d;
    end
  end

  // Line storage needs no reset; only bytes below wr_ptr are ever read.
  always_ff @(posedge sys_clk) begin
    if (mem_we) line_mem[wr_ptr_q[PtrW-1:0]] <= rx_data;
  end

  assign tx_valid  = (state_q == StSend) || (state_q == StCr) || (state_q == StLf);
  assign busy      = (state_q != StRecv);
  assign tx_data   = tx_data_q;
  assign line_done = line_done_q;
  assign line_len  = line_len_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign last_rx   = last_rx_q;

endmodule
